// File: rtl/wired_rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wired_rename_pkg
//  Description : Shared types and helpers for the N-wide Wired rename stage.
//                Architectural and ROB id types, the per-slot rename result
//                record, and a population-count helper.
//  Revision    : 1.0 - initial parametrised N-wide release
// ============================================================================
package wired_rename_pkg;

  localparam int c_ARCH_W        = 5;
  localparam int c_PKG_ROB_DEPTH = 64;
  localparam int c_PKG_RID_W     = $clog2(c_PKG_ROB_DEPTH);

  typedef logic [c_PKG_RID_W-1:0] rob_rid_t;
  typedef logic [c_ARCH_W-1:0]    arch_rid_t;

  // One renamed slot: two source operands plus the allocated destination.
  typedef struct packed {
    rob_rid_t [1:0] rrid;
    logic     [1:0] arf_valid;
    rob_rid_t       wrid;
    logic           tier;
  } rename_out_t;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wired_rename_nw_if.sv
`default_nettype none
// ============================================================================
//  Module      : wired_rename_nw_if
//  Description : Bundle of the rename stage's frontend, dispatch and commit
//                signals.
//                slave  : the rename stage view
//                master : the surrounding pipeline view
//  Ports       : frontend group (in_*, rarid_i, warid_i), dispatch group
//                (out_*), commit feedback (c_*), empty_o status.
//  Revision    : 1.0 - initial parametrised N-wide release
// ============================================================================
interface wired_rename_nw_if #(
  parameter int WIDTH        = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int RID_W        = 6
) ();

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [WIDTH-1:0]            in_mask_i;
  logic [WIDTH*2*5-1:0]        rarid_i;
  logic [WIDTH*5-1:0]          warid_i;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [WIDTH-1:0]            out_mask_o;
  logic [WIDTH*2*RID_W-1:0]    out_rrid_o;
  logic [WIDTH*2-1:0]          out_arf_valid_o;
  logic [WIDTH*RID_W-1:0]      out_wrid_o;
  logic [WIDTH-1:0]            out_tier_o;

  logic [RETIRE_WIDTH-1:0]     c_retire_i;
  logic [RETIRE_WIDTH*5-1:0]   c_warid_i;
  logic [RETIRE_WIDTH*RID_W-1:0] c_wrid_i;
  logic                        c_flush_i;

  logic                        empty_o;

  modport slave (
    input  in_valid_i, in_mask_i, rarid_i, warid_i, out_ready_i,
           c_retire_i, c_warid_i, c_wrid_i, c_flush_i,
    output in_ready_o, out_valid_o, out_mask_o, out_rrid_o,
           out_arf_valid_o, out_wrid_o, out_tier_o, empty_o
  );

  modport master (
    output in_valid_i, in_mask_i, rarid_i, warid_i, out_ready_i,
           c_retire_i, c_warid_i, c_wrid_i, c_flush_i,
    input  in_ready_o, out_valid_o, out_mask_o, out_rrid_o,
           out_arf_valid_o, out_wrid_o, out_tier_o, empty_o
  );

endinterface
`default_nettype wire

// File: rtl/wired_rename_table.sv
`default_nettype none
// ============================================================================
//  Module      : wired_rename_table
//  Description : Architectural-to-ROB rename table. Per arch register a
//                pending bit and the producer ROB id. Multi-port lookup of
//                the current (pre-update) state, youngest-slot-wins write,
//                and retire clear only when the retiring id is still the
//                latest producer.
//  Ports       : clk, rst_n (sync, active low), i_flush
//                i_rarid -> o_pend / o_rid   : lookup ports
//                i_wen, i_warid, i_wrid      : rename writes
//                i_ret, i_ret_arid, i_ret_rid: retire clears
//  Revision    : 1.0 - initial parametrised N-wide release
// ============================================================================
module wired_rename_table
  import wired_rename_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int ARCH_DEPTH   = 32,
  parameter int RID_W        = 6,
  parameter int N_SRC        = 2 * WIDTH
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_flush,
  input  wire arch_rid_t               i_rarid    [N_SRC],
  output logic                         o_pend     [N_SRC],
  output logic [RID_W-1:0]             o_rid      [N_SRC],
  input  wire logic [WIDTH-1:0]        i_wen,
  input  wire arch_rid_t               i_warid    [WIDTH],
  input  wire logic [RID_W-1:0]        i_wrid     [WIDTH],
  input  wire logic [RETIRE_WIDTH-1:0] i_ret,
  input  wire arch_rid_t               i_ret_arid [RETIRE_WIDTH],
  input  wire logic [RID_W-1:0]        i_ret_rid  [RETIRE_WIDTH]
);

  logic [ARCH_DEPTH-1:0] r_pend;
  logic [RID_W-1:0]      r_id     [ARCH_DEPTH];

  logic [ARCH_DEPTH-1:0] w_set;
  logic [ARCH_DEPTH-1:0] w_clr;
  logic [RID_W-1:0]      w_set_id [ARCH_DEPTH];

  // Lookups see the table as it stood at the start of the cycle; same-group
  // producers are resolved by the bypass in the top level.
  always_comb begin
    for (int n = 0; n < N_SRC; n++) begin
      o_pend[n] = (i_rarid[n] != '0) && r_pend[i_rarid[n]];
      o_rid[n]  = r_id[i_rarid[n]];
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int a = 0; a < ARCH_DEPTH; a++) begin
      w_set_id[a] = r_id[a];
      // Ascending slot order so the youngest writer of a register lands last.
      for (int k = 0; k < WIDTH; k++) begin
        if ((a != 0) && i_wen[k] && (i_warid[k] == arch_rid_t'(a))) begin
          w_set[a]    = 1'b1;
          w_set_id[a] = i_wrid[k];
        end
      end
      // Only the latest producer may clear: an older retire must not release
      // a register that has since been renamed again.
      for (int r = 0; r < RETIRE_WIDTH; r++) begin
        if ((a != 0) && i_ret[r] && (i_ret_arid[r] == arch_rid_t'(a)) &&
            r_pend[a] && (r_id[a] == i_ret_rid[r])) begin
          w_clr[a] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int a = 0; a < ARCH_DEPTH; a++) begin
        r_id[a] <= '0;
      end
    end else if (i_flush) begin
      r_pend <= '0;
    end else begin
      for (int a = 0; a < ARCH_DEPTH; a++) begin
        if (w_set[a]) begin
          r_pend[a] <= 1'b1;
          r_id[a]   <= w_set_id[a];
        end else if (w_clr[a]) begin
          r_pend[a] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wired_rename_nw.sv
`default_nettype none
// ============================================================================
//  Module      : wired_rename_nw
//  Description : N-wide register-rename stage. Looks up source producers,
//                bypasses same-group producers, allocates ROB ids with a
//                wrap-phase (tier) bit, tracks ROB occupancy for
//                back-pressure and presents the result through a registered
//                valid/ready stage.
//  Ports       : clk, rst_n (sync, active low)
//                bus (wired_rename_nw_if.slave): frontend group in, renamed
//                group out, commit retire/flush feedback, empty_o status.
//  Revision    : 1.0 - initial parametrised N-wide release
// ============================================================================
module wired_rename_nw
  import wired_rename_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int ARCH_DEPTH   = 32,
  parameter int ROB_DEPTH    = 64,
  parameter int RID_W        = $clog2(ROB_DEPTH)
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  wired_rename_nw_if.slave bus
);

  localparam int              c_N_SRC     = 2 * WIDTH;
  localparam logic [RID_W:0]  c_ROB_DEPTH = (RID_W+1)'(ROB_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [RID_W-1:0] r_tail;
  logic             r_tier;
  logic [RID_W:0]   r_count;
  logic             r_empty;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_mask;
  rename_out_t      r_out [WIDTH];

  // --------------------------------------------------------------------------
  // Unpacked views of the flat bus fields
  // --------------------------------------------------------------------------
  arch_rid_t        w_rarid     [c_N_SRC];
  arch_rid_t        w_warid     [WIDTH];
  arch_rid_t        w_ret_arid  [RETIRE_WIDTH];
  logic [RID_W-1:0] w_ret_rid   [RETIRE_WIDTH];

  for (genvar n = 0; n < c_N_SRC; n++) begin : g_rarid
    assign w_rarid[n] = bus.rarid_i[n*c_ARCH_W +: c_ARCH_W];
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_warid
    assign w_warid[k] = bus.warid_i[k*c_ARCH_W +: c_ARCH_W];
  end

  for (genvar r = 0; r < RETIRE_WIDTH; r++) begin : g_ret
    assign w_ret_arid[r] = bus.c_warid_i[r*c_ARCH_W +: c_ARCH_W];
    assign w_ret_rid[r]  = bus.c_wrid_i[r*RID_W +: RID_W];
  end

  // --------------------------------------------------------------------------
  // Occupancy and handshake
  // --------------------------------------------------------------------------
  logic [RID_W:0] w_req;
  logic [RID_W:0] w_free;
  logic [RID_W:0] w_ret_n;
  logic [RID_W:0] w_count_next;
  logic [RID_W:0] w_tail_sum;
  logic           w_in_ready;
  logic           w_accept;

  assign w_req   = (RID_W+1)'(popcount(32'(bus.in_mask_i)));
  assign w_ret_n = (RID_W+1)'(popcount(32'(bus.c_retire_i)));
  assign w_free  = c_ROB_DEPTH - r_count;

  // Reset term keeps ready low while rst_n is asserted, before the
  // registered state has been cleared.
  assign w_in_ready = rst_n & ~bus.c_flush_i & (~r_out_valid | bus.out_ready_i)
                    & (w_free >= w_req);
  assign w_accept   = bus.in_valid_i & w_in_ready;

  assign w_count_next = r_count + (w_accept ? w_req : '0) - w_ret_n;
  assign w_tail_sum   = {1'b0, r_tail} + w_req;

  // --------------------------------------------------------------------------
  // Per-slot allocation: id = tail + k, tier flips on the slot that wraps
  // --------------------------------------------------------------------------
  logic [RID_W:0]   w_slot_sum  [WIDTH];
  logic [RID_W-1:0] w_slot_rid  [WIDTH];
  logic             w_slot_tier [WIDTH];

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      w_slot_sum[k]  = {1'b0, r_tail} + (RID_W+1)'(k);
      w_slot_rid[k]  = w_slot_sum[k][RID_W-1:0];
      w_slot_tier[k] = r_tier ^ w_slot_sum[k][RID_W];
    end
  end

  // --------------------------------------------------------------------------
  // Rename table
  // --------------------------------------------------------------------------
  logic             w_src_pend [c_N_SRC];
  logic [RID_W-1:0] w_src_rid  [c_N_SRC];
  logic [WIDTH-1:0] w_wen;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      w_wen[k] = w_accept & bus.in_mask_i[k] & (w_warid[k] != '0);
    end
  end

  wired_rename_table #(
    .WIDTH        (WIDTH),
    .RETIRE_WIDTH (RETIRE_WIDTH),
    .ARCH_DEPTH   (ARCH_DEPTH),
    .RID_W        (RID_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (bus.c_flush_i),
    .i_rarid    (w_rarid),
    .o_pend     (w_src_pend),
    .o_rid      (w_src_rid),
    .i_wen      (w_wen),
    .i_warid    (w_warid),
    .i_wrid     (w_slot_rid),
    .i_ret      (bus.c_retire_i),
    .i_ret_arid (w_ret_arid),
    .i_ret_rid  (w_ret_rid)
  );

  // --------------------------------------------------------------------------
  // Source resolution with intra-group bypass
  // --------------------------------------------------------------------------
  rename_out_t w_slot_out [WIDTH];

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      w_slot_out[j] = '0;
      if (bus.in_mask_i[j]) begin
        w_slot_out[j].wrid = w_slot_rid[j];
        w_slot_out[j].tier = w_slot_tier[j];
        for (int s = 0; s < 2; s++) begin
          w_slot_out[j].arf_valid[s] = ~w_src_pend[j*2+s];
          w_slot_out[j].rrid[s]      = w_src_pend[j*2+s] ? w_src_rid[j*2+s] : '0;
          // Older slots scanned in ascending order: the nearest older
          // producer overrides any earlier one and the table entry.
          for (int i = 0; i < WIDTH; i++) begin
            if ((i < j) && bus.in_mask_i[i] && (w_warid[i] != '0) &&
                (w_warid[i] == w_rarid[j*2+s])) begin
              w_slot_out[j].arf_valid[s] = 1'b0;
              w_slot_out[j].rrid[s]      = w_slot_rid[i];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Allocation pointer and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tail  <= '0;
      r_tier  <= 1'b0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else if (bus.c_flush_i) begin
      r_tail  <= '0;
      r_tier  <= 1'b0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_accept) begin
        r_tail <= w_tail_sum[RID_W-1:0];
        r_tier <= r_tier ^ w_tail_sum[RID_W];
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
    end
  end

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        r_out[k] <= '0;
      end
    end else if (bus.c_flush_i) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_mask  <= bus.in_mask_i;
      r_out       <= w_slot_out;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_mask_o  = r_out_mask;
  assign bus.empty_o     = r_empty;

  for (genvar k = 0; k < WIDTH; k++) begin : g_out
    assign bus.out_wrid_o[k*RID_W +: RID_W] = r_out[k].wrid;
    assign bus.out_tier_o[k]                = r_out[k].tier;
    for (genvar s = 0; s < 2; s++) begin : g_src
      assign bus.out_rrid_o[(k*2+s)*RID_W +: RID_W] = r_out[k].rrid[s];
      assign bus.out_arf_valid_o[k*2+s]             = r_out[k].arf_valid[s];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wired_rename_nw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wired_rename_nw
//  Description : Directed self-checking bench for wired_rename_nw (2-wide,
//                64-entry ROB). One task per scenario; expected values are
//                hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wired_rename_nw;

  localparam int WIDTH = 2;
  localparam int RW    = 2;
  localparam int RID_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_xfer = 0;

  always #5 clk = ~clk;

  wired_rename_nw_if #(.WIDTH(WIDTH), .RETIRE_WIDTH(RW), .RID_W(RID_W)) bus_if ();

  wired_rename_nw #(
    .WIDTH        (WIDTH),
    .RETIRE_WIDTH (RW),
    .ARCH_DEPTH   (32),
    .ROB_DEPTH    (64),
    .RID_W        (RID_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // Dispatch transfers seen at the clock edge.
  always @(posedge clk) begin
    if (rst_n && bus_if.out_valid_o && bus_if.out_ready_i) n_xfer++;
  end

  // Retiring with an empty ROB is an illegal stimulus.
  always @(posedge clk) begin
    if (rst_n && !bus_if.c_flush_i && (bus_if.c_retire_i != '0) && bus_if.empty_o)
      $error("retire issued while ROB empty");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------------ drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.in_valid_i  = 1'b0;
    bus_if.in_mask_i   = '0;
    bus_if.rarid_i     = '0;
    bus_if.warid_i     = '0;
    bus_if.out_ready_i = 1'b1;
    bus_if.c_retire_i  = '0;
    bus_if.c_warid_i   = '0;
    bus_if.c_wrid_i    = '0;
    bus_if.c_flush_i   = 1'b0;
  endtask

  // Sources: s0a/s0b belong to slot 0, s1a/s1b to slot 1.
  task automatic drive_group(input logic [1:0] mask,
                             input logic [4:0] s0a, input logic [4:0] s0b,
                             input logic [4:0] s1a, input logic [4:0] s1b,
                             input logic [4:0] w0,  input logic [4:0] w1);
    bus_if.in_valid_i = 1'b1;
    bus_if.in_mask_i  = mask;
    bus_if.rarid_i    = {s1b, s1a, s0b, s0a};
    bus_if.warid_i    = {w1, w0};
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2);
    step();
    step();
    n_vec++; if (bus_if.in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready_o); end
    n_vec++; if (bus_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid_o); end
    n_vec++; if (bus_if.out_mask_o !== 2'b00) begin n_err++; $display("FAIL reset_out_mask: got %b want 00", bus_if.out_mask_o); end
    n_vec++; if (bus_if.empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus_if.empty_o); end
    n_vec++; if ({bus_if.out_wrid_o, bus_if.out_rrid_o, bus_if.out_arf_valid_o, bus_if.out_tier_o} !== 42'h0) begin
      n_err++; $display("FAIL reset_outputs: got wrid %h rrid %h arf %b tier %b want all 0",
                        bus_if.out_wrid_o, bus_if.out_rrid_o, bus_if.out_arf_valid_o, bus_if.out_tier_o); end
    idle();
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus_if.in_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", bus_if.in_ready_o); end
    step();
  endtask

  task automatic test_first_group();
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd5);
    step();
    idle();
    n_vec++; if (bus_if.out_valid_o !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus_if.out_valid_o); end
    n_vec++; if (bus_if.out_mask_o !== 2'b11) begin n_err++; $display("FAIL first_mask: got %b want 11", bus_if.out_mask_o); end
    n_vec++; if (bus_if.out_wrid_o !== 12'h040) begin n_err++; $display("FAIL first_wrid: got %h want 040", bus_if.out_wrid_o); end
    n_vec++; if (bus_if.out_tier_o !== 2'b00) begin n_err++; $display("FAIL first_tier: got %b want 00", bus_if.out_tier_o); end
    n_vec++; if (bus_if.out_arf_valid_o !== 4'b1111) begin n_err++; $display("FAIL first_arf: got %b want 1111", bus_if.out_arf_valid_o); end
    n_vec++; if (bus_if.out_rrid_o !== 24'h0) begin n_err++; $display("FAIL first_rrid: got %h want 000000", bus_if.out_rrid_o); end
    n_vec++; if (bus_if.empty_o !== 1'b0) begin n_err++; $display("FAIL first_empty: got %b want 0", bus_if.empty_o); end
    step();
    n_vec++; if (bus_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL first_consumed: got %b want 0", bus_if.out_valid_o); end
  endtask

  // Continues from test_first_group: tail=2, r3->0, r5->1.
  task automatic test_bypass();
    drive_group(2'b11, 5'd5, 5'd0, 5'd3, 5'd4, 5'd3, 5'd0);
    step();
    idle();
    n_vec++; if (bus_if.out_rrid_o !== 24'h002001) begin n_err++; $display("FAIL bypass_rrid: got %h want 002001", bus_if.out_rrid_o); end
    n_vec++; if (bus_if.out_arf_valid_o !== 4'b1010) begin n_err++; $display("FAIL bypass_arf: got %b want 1010", bus_if.out_arf_valid_o); end
    n_vec++; if (bus_if.out_wrid_o !== 12'h0C2) begin n_err++; $display("FAIL bypass_wrid: got %h want 0c2", bus_if.out_wrid_o); end
    // Both slots write r6 (ids 4,5); the younger must own the table entry.
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd6);
    step();
    drive_group(2'b01, 5'd6, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    idle();
    n_vec++; if (bus_if.out_rrid_o[11:0] !== 12'h085) begin n_err++; $display("FAIL youngest_rrid: got %h want 085", bus_if.out_rrid_o[11:0]); end
    n_vec++; if (bus_if.out_arf_valid_o[1:0] !== 2'b00) begin n_err++; $display("FAIL youngest_arf: got %b want 00", bus_if.out_arf_valid_o[1:0]); end
    n_vec++; if (bus_if.out_wrid_o[5:0] !== 6'd6) begin n_err++; $display("FAIL youngest_wrid: got %0d want 6", bus_if.out_wrid_o[5:0]); end
    n_vec++; if (bus_if.out_mask_o !== 2'b01) begin n_err++; $display("FAIL youngest_mask: got %b want 01", bus_if.out_mask_o); end
  endtask

  task automatic test_retire_order();
    do_reset();
    drive_group(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0);  // r3 -> 0
    step();
    drive_group(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0);  // r3 -> 1
    step();
    idle();
    bus_if.c_retire_i = 2'b01;
    bus_if.c_warid_i  = {5'd0, 5'd3};
    bus_if.c_wrid_i   = {6'd0, 6'd0};
    step();
    idle();
    drive_group(2'b01, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);  // id 2
    step();
    idle();
    n_vec++; if (bus_if.out_rrid_o[5:0] !== 6'd1) begin n_err++; $display("FAIL stale_retire_rrid: got %0d want 1", bus_if.out_rrid_o[5:0]); end
    n_vec++; if (bus_if.out_arf_valid_o[1:0] !== 2'b10) begin n_err++; $display("FAIL stale_retire_arf: got %b want 10", bus_if.out_arf_valid_o[1:0]); end
    bus_if.c_retire_i = 2'b11;
    bus_if.c_warid_i  = {5'd0, 5'd3};
    bus_if.c_wrid_i   = {6'd2, 6'd1};
    step();
    idle();
    n_vec++; if (bus_if.empty_o !== 1'b1) begin n_err++; $display("FAIL retire_empty: got %b want 1", bus_if.empty_o); end
    drive_group(2'b01, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);  // id 3
    step();
    idle();
    n_vec++; if (bus_if.out_arf_valid_o[0] !== 1'b1) begin n_err++; $display("FAIL cleared_arf: got %b want 1", bus_if.out_arf_valid_o[0]); end
    n_vec++; if (bus_if.out_rrid_o[5:0] !== 6'd0) begin n_err++; $display("FAIL cleared_rrid: got %0d want 0", bus_if.out_rrid_o[5:0]); end
    n_vec++; if (bus_if.out_wrid_o[5:0] !== 6'd3) begin n_err++; $display("FAIL cleared_wrid: got %0d want 3", bus_if.out_wrid_o[5:0]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int g = 0; g < 32; g++) begin
      drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      step();
    end
    n_vec++; if (bus_if.in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", bus_if.in_ready_o); end
    bus_if.c_retire_i = 2'b11;
    bus_if.c_warid_i  = '0;
    bus_if.c_wrid_i   = {6'd1, 6'd0};
    #1;
    n_vec++; if (bus_if.in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_retire_cycle_ready: got %b want 0", bus_if.in_ready_o); end
    step();
    bus_if.c_retire_i = '0;
    bus_if.c_wrid_i   = '0;
    #1;
    n_vec++; if (bus_if.in_ready_o !== 1'b1) begin n_err++; $display("FAIL after_retire_ready: got %b want 1", bus_if.in_ready_o); end
    step();
    idle();
    n_vec++; if (bus_if.out_wrid_o !== 12'h040) begin n_err++; $display("FAIL wrap_wrid: got %h want 040", bus_if.out_wrid_o); end
    n_vec++; if (bus_if.out_tier_o !== 2'b11) begin n_err++; $display("FAIL wrap_tier: got %b want 11", bus_if.out_tier_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_if.out_ready_i = 1'b0;
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd8);
    step();
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd10);
    n_xfer = 0;
    for (int c = 0; c < 3; c++) begin
      n_vec++; if ({bus_if.out_valid_o, bus_if.out_mask_o, bus_if.out_wrid_o} !== {1'b1, 2'b11, 12'h040}) begin
        n_err++; $display("FAIL hold_outputs cycle %0d: got v%b m%b w%h want v1 m11 w040",
                          c, bus_if.out_valid_o, bus_if.out_mask_o, bus_if.out_wrid_o); end
      n_vec++; if (bus_if.in_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_in_ready cycle %0d: got %b want 0", c, bus_if.in_ready_o); end
      step();
    end
    bus_if.out_ready_i = 1'b1;
    #1;
    n_vec++; if (bus_if.in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", bus_if.in_ready_o); end
    step();
    idle();
    n_vec++; if (bus_if.out_wrid_o !== 12'h0C2) begin n_err++; $display("FAIL release_wrid: got %h want 0c2", bus_if.out_wrid_o); end
    step();
    n_vec++; if (bus_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL release_drain: got %b want 0", bus_if.out_valid_o); end
    step();
    n_vec++; if (n_xfer !== 2) begin n_err++; $display("FAIL transfer_count: got %0d want 2", n_xfer); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd10);
      step();
    end
    n_vec++; if (bus_if.empty_o !== 1'b0) begin n_err++; $display("FAIL preflush_empty: got %b want 0", bus_if.empty_o); end
    drive_group(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd11, 5'd12);
    bus_if.c_flush_i = 1'b1;
    #1;
    n_vec++; if (bus_if.in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", bus_if.in_ready_o); end
    step();
    idle();
    n_vec++; if (bus_if.out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", bus_if.out_valid_o); end
    n_vec++; if (bus_if.empty_o !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", bus_if.empty_o); end
    drive_group(2'b11, 5'd9, 5'd10, 5'd10, 5'd9, 5'd0, 5'd0);
    step();
    idle();
    n_vec++; if (bus_if.out_arf_valid_o !== 4'b1111) begin n_err++; $display("FAIL flush_arf: got %b want 1111", bus_if.out_arf_valid_o); end
    n_vec++; if (bus_if.out_rrid_o !== 24'h0) begin n_err++; $display("FAIL flush_rrid: got %h want 000000", bus_if.out_rrid_o); end
    n_vec++; if ({bus_if.out_wrid_o, bus_if.out_tier_o} !== {12'h040, 2'b00}) begin
      n_err++; $display("FAIL flush_wrid: got w%h t%b want w040 t00", bus_if.out_wrid_o, bus_if.out_tier_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_first_group();
    test_bypass();
    test_retire_order();
    test_full();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wired_rename_nw.md
Name: wired_rename_nw

Overview:
- Parametrised N-wide register-rename stage for the Wired out-of-order backend; successor to the fixed 2-wide renamer.
- Maps architectural source and destination registers to ROB ids and allocates ROB entries with a wrap-phase (tier) bit.
- Adds intra-group dependency bypass, ROB occupancy back-pressure and a registered valid/ready output stage.
- Sits between the frontend packet input and the dispatch (P) stage; fed back by commit retire and flush.

Parameters:
- WIDTH, 2, instructions renamed per cycle.
- RETIRE_WIDTH, 2, commit retire slots per cycle.
- ARCH_DEPTH, 32, architectural registers; register 0 is hard zero.
- ROB_DEPTH, 64, ROB entries; power of two.
- RID_W, $clog2(ROB_DEPTH), ROB index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  group valid
- in_ready_o  out  1  group accepted when in_valid_i & in_ready_o
- in_mask_i  in  WIDTH  per-slot active; bits contiguous from slot 0
- rarid_i  in  WIDTH*2*5  source arch ids, two per slot
- warid_i  in  WIDTH*5  destination arch id per slot
- out_valid_o  out  1  renamed group valid
- out_ready_i  in  1  P stage accepts
- out_mask_o  out  WIDTH  registered in_mask_i
- out_rrid_o  out  WIDTH*2*RID_W  source ROB ids
- out_arf_valid_o  out  WIDTH*2  1 = operand is in the ARF, not the ROB
- out_wrid_o  out  WIDTH*RID_W  allocated ROB id
- out_tier_o  out  WIDTH  wrap-phase bit of the allocated entry
- c_retire_i  in  RETIRE_WIDTH  retire slots; contiguous from bit 0
- c_warid_i  in  RETIRE_WIDTH*5  destination arch id of each retiring entry
- c_wrid_i  in  RETIRE_WIDTH*RID_W  ROB id of each retiring entry
- c_flush_i  in  1  pipeline flush
- empty_o  out  1  no ROB entries in flight

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All table valid bits cleared; tail=0; tier=0; count=0.
  - out_valid_o=0, out_mask_o=0, all other outputs 0.
  - empty_o=1; in_ready_o=0 during the reset cycle.
- Table: per arch register, a pending bit plus the producer ROB id. Register 0 is never pending.
- in_ready_o = !c_flush_i & (!out_valid_o | out_ready_i) & (ROB_DEPTH - count >= popcount(in_mask_i)). This path is combinational.
- Source lookup on the accept cycle:
  - If arid==0 or the register is not pending: arf_valid=1, rrid=0.
  - Otherwise: arf_valid=0, rrid=table id.
  - Intra-group bypass: if an earlier active slot i<j in the same group writes a nonzero arid equal to slot j's source, slot j takes slot i's allocated id with arf_valid=0; the youngest such i wins.
- Allocation:
  - Slot k gets id (tail+k) mod ROB_DEPTH; its tier is the current tier, flipped if tail+k wraps.
  - On accept, tail advances by popcount; tier toggles when tail wraps.
  - Every active slot allocates an entry, including writes to register 0.
- Table write: each active slot with warid != 0 sets pending and the new id. For two slots writing the same arch register, the youngest slot wins.
- Retire: for each c_retire_i bit with c_warid != 0, clear pending only if table id == c_wrid (a younger rename has not overwritten it). A same-cycle rename write to that register wins over the clear.
- count_next = count + alloc - popcount(c_retire_i). Alloc and retire may happen in the same cycle. Retire when count==0 is illegal; the bench asserts against it.
- Output stage:
  - Latency 1: accepted at cycle t, visible at t+1.
  - Held stable while out_valid_o & !out_ready_i.
  - Cleared when consumed with no new accept.
- Flush (c_flush_i=1):
  - Next cycle: all pending bits cleared, tail=0, tier=0, count=0, out_valid_o=0.
  - No accept in the flush cycle; retire inputs in the flush cycle are ignored.
  - Flush has priority over every other update.
- empty_o = (count==0), registered state.

Decomposition:
- Shared package wired_rename_pkg holds:
  - typedef rob_rid_t (RID_W bits); arch_rid_t (5 bits).
  - struct rename_out_t {rrid, arf_valid, wrid, tier}.
  - popcount function.
- One sub-module, wired_rename_table: the table with multi-port lookup, youngest-wins write and conditional retire clear.
- Bypass, allocation, counter and output register stay in the top module.

Test Plan:
- Reset, then group mask=2'b11, warid={5,3}, rarid all 0 -> next cycle wrid={1,0}, tier={0,0}, arf_valid all 1, empty_o=0.
- Slot0 writes r3; slot1 reads r3 in the same group -> slot1 rrid=slot0 id, arf_valid=0. Slot1 reading r4 (not pending) -> arf_valid=1.
- Rename r3 to id 0, then r3 again to id 1; retire id 0 -> r3 stays pending with id 1. Retire id 1 -> r3 cleared; the next read of r3 gives arf_valid=1.
- Fill 64 entries with no retire, then offer mask=2'b11 -> in_ready_o=0. Retire 2 -> in_ready_o=1 the next cycle; allocated ids 0,1 carry tier=1.
- Hold out_ready_i=0 for 3 cycles with a valid group -> outputs stable and in_ready_o=0; release -> one transfer and no duplicate.
- Mid-stream flush with count=10 while in_valid_i=1 -> no accept that cycle; next cycle out_valid_o=0, empty_o=1, all reads arf_valid=1, first new wrid=0.
